rb_bus_arbiter: RTL and testbench

Shares the single register-bank port (address, write data, reg_en, write_en, read data) between the I2C and UART host interfaces. Each host's one-cycle access strobe is captured into a per-host pending slot, and the slots are served one at a time in round-robin order. Write data goes to the bank; read data is returned to the originating host through a held, registered value plus a one-cycle valid pulse. The block sits between `i2c_if`/`uart_if` and `rb_fpga_template` in the top level, replacing the direct UART-only connection.

---
 rtl/rb_bus_arbiter.sv | 173 +++++++++++++++++
 tb/tb_rb_bus_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/rb_bus_arbiter.sv
// Round-robin arbiter sharing one register-bank port between the I2C host (0) and the UART host (1).
// Each host strobe is captured into a pending slot; slots are served one at a time via IDLE -> ISSUE -> RESP.
module rb_bus_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          resetb,
   input  logic [AW-1:0] h0_address,
   input  logic [DW-1:0] h0_wdata,
   input  logic          h0_reg_en,
   input  logic          h0_write_en,
   output logic [DW-1:0] h0_rdata,
   output logic          h0_rvalid,
   output logic          h0_busy,
   input  logic [AW-1:0] h1_address,
   input  logic [DW-1:0] h1_wdata,
   input  logic          h1_reg_en,
   input  logic          h1_write_en,
   output logic [DW-1:0] h1_rdata,
   output logic          h1_rvalid,
   output logic          h1_busy,
   output logic [AW-1:0] rb_address,
   output logic [DW-1:0] rb_wdata,
   output logic          rb_reg_en,
   output logic          rb_write_en,
   input  logic [DW-1:0] rb_rdata,
   output logic [1:0]    ovf_sticky,
   output logic [1:0]    arb_state_mon
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t r_state, w_state_next;
   logic   r_g;
   logic   r_last;
   logic   w_grant;
   logic   w_start;

   logic [AW-1:0] r_rb_address;
   logic [DW-1:0] r_rb_wdata;
   logic          r_rb_reg_en;
   logic          r_rb_write_en;

   logic [AW-1:0] w_in_addr  [2];
   logic [DW-1:0] w_in_wdata [2];
   logic [1:0]    w_in_en;
   logic [1:0]    w_in_we;

   logic [AW-1:0] w_slot_addr  [2];
   logic [DW-1:0] w_slot_wdata [2];
   logic [DW-1:0] w_rdata      [2];
   logic [1:0]    w_slot_vld;
   logic [1:0]    w_slot_we;
   logic [1:0]    w_rvalid;
   logic [1:0]    w_ovf;

   assign w_in_addr[0]  = h0_address;
   assign w_in_addr[1]  = h1_address;
   assign w_in_wdata[0] = h0_wdata;
   assign w_in_wdata[1] = h1_wdata;
   assign w_in_en       = {h1_reg_en, h0_reg_en};
   assign w_in_we       = {h1_write_en, h0_write_en};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_host
         logic [AW-1:0] r_addr;
         logic [DW-1:0] r_wdata;
         logic [DW-1:0] r_rdata;
         logic          r_vld;
         logic          r_we;
         logic          r_rvalid;
         logic          r_ovf;
         logic          w_release;
         logic          w_read_done;

         assign w_release   = (r_state == RESP) && (r_g == 1'(gi));
         assign w_read_done = (r_state == ISSUE) && (r_g == 1'(gi)) && !r_we;

         always_ff @(posedge clk) begin
            if (!resetb) begin
               r_addr   <= '0;
               r_wdata  <= '0;
               r_rdata  <= '0;
               r_vld    <= 1'b0;
               r_we     <= 1'b0;
               r_rvalid <= 1'b0;
               r_ovf    <= 1'b0;
            end else begin
               // Read data is registered at the end of ISSUE so it appears with rvalid during RESP.
               r_rvalid <= w_read_done;
               if (w_read_done)
                  r_rdata <= rb_rdata;
               // A strobe arriving while the slot is released wins over the clear.
               if (w_in_en[gi] && (!r_vld || w_release)) begin
                  r_vld   <= 1'b1;
                  r_addr  <= w_in_addr[gi];
                  r_wdata <= w_in_wdata[gi];
                  r_we    <= w_in_we[gi];
               end else if (w_release) begin
                  r_vld <= 1'b0;
               end
               if (w_in_en[gi] && r_vld && !w_release)
                  r_ovf <= 1'b1;
            end
         end

         assign w_slot_addr[gi]  = r_addr;
         assign w_slot_wdata[gi] = r_wdata;
         assign w_slot_vld[gi]   = r_vld;
         assign w_slot_we[gi]    = r_we;
         assign w_rdata[gi]      = r_rdata;
         assign w_rvalid[gi]     = r_rvalid;
         assign w_ovf[gi]        = r_ovf;
      end
   endgenerate

   // Both pending: pick the host not served last; otherwise the only pending one.
   assign w_grant = (&w_slot_vld) ? ~r_last : w_slot_vld[1];
   assign w_start = (r_state == IDLE) && (|w_slot_vld);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (|w_slot_vld) w_state_next = ISSUE;
         ISSUE:   w_state_next = RESP;
         RESP:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetb) begin
         r_state       <= IDLE;
         r_g           <= 1'b0;
         r_last        <= 1'b1;
         r_rb_address  <= '0;
         r_rb_wdata    <= '0;
         r_rb_reg_en   <= 1'b0;
         r_rb_write_en <= 1'b0;
      end else begin
         r_state <= w_state_next;
         // Bank strobes are decoded one cycle early so they are flop outputs during ISSUE.
         r_rb_reg_en   <= w_start;
         r_rb_write_en <= w_start && w_slot_we[w_grant];
         if (w_start) begin
            r_g          <= w_grant;
            r_last       <= w_grant;
            r_rb_address <= w_slot_addr[w_grant];
            r_rb_wdata   <= w_slot_wdata[w_grant];
         end
      end
   end

   assign rb_address    = r_rb_address;
   assign rb_wdata      = r_rb_wdata;
   assign rb_reg_en     = r_rb_reg_en;
   assign rb_write_en   = r_rb_write_en;
   assign h0_rdata      = w_rdata[0];
   assign h1_rdata      = w_rdata[1];
   assign h0_rvalid     = w_rvalid[0];
   assign h1_rvalid     = w_rvalid[1];
   assign h0_busy       = w_slot_vld[0];
   assign h1_busy       = w_slot_vld[1];
   assign ovf_sticky    = w_ovf;
   assign arb_state_mon = r_state;

endmodule

// File: tb/tb_rb_bus_arbiter.sv
// Directed bench for rb_bus_arbiter: the bank is a fixed function of address (addr ^ 0x3D),
// stimulus is applied and outputs are checked on the falling clock edge.
module tb_rb_bus_arbiter;

   logic       clk = 1'b0;
   logic       resetb;
   logic [7:0] h0_address, h0_wdata, h0_rdata;
   logic       h0_reg_en, h0_write_en, h0_rvalid, h0_busy;
   logic [7:0] h1_address, h1_wdata, h1_rdata;
   logic       h1_reg_en, h1_write_en, h1_rvalid, h1_busy;
   logic [7:0] rb_address, rb_wdata, rb_rdata;
   logic       rb_reg_en, rb_write_en;
   logic [1:0] ovf_sticky, arb_state_mon;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   assign rb_rdata = rb_address ^ 8'h3D;

   rb_bus_arbiter #(.AW(8), .DW(8)) dut (
      .clk(clk), .resetb(resetb),
      .h0_address(h0_address), .h0_wdata(h0_wdata), .h0_reg_en(h0_reg_en),
      .h0_write_en(h0_write_en), .h0_rdata(h0_rdata), .h0_rvalid(h0_rvalid), .h0_busy(h0_busy),
      .h1_address(h1_address), .h1_wdata(h1_wdata), .h1_reg_en(h1_reg_en),
      .h1_write_en(h1_write_en), .h1_rdata(h1_rdata), .h1_rvalid(h1_rvalid), .h1_busy(h1_busy),
      .rb_address(rb_address), .rb_wdata(rb_wdata), .rb_reg_en(rb_reg_en),
      .rb_write_en(rb_write_en), .rb_rdata(rb_rdata),
      .ovf_sticky(ovf_sticky), .arb_state_mon(arb_state_mon)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic drive(input int h, input logic en, input logic [7:0] a,
                        input logic [7:0] d, input logic we);
      if (h == 0) begin
         h0_reg_en = en; h0_address = a; h0_wdata = d; h0_write_en = we;
      end else begin
         h1_reg_en = en; h1_address = a; h1_wdata = d; h1_write_en = we;
      end
   endtask

   initial begin
      resetb = 1'b0;
      drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      repeat (3) cyc();
      chk("rst_reg_en", rb_reg_en, 1'b0);
      chk("rst_write_en", rb_write_en, 1'b0);
      chk("rst_address", rb_address, 8'h00);
      chk("rst_wdata", rb_wdata, 8'h00);
      chk("rst_rdata", {h1_rdata, h0_rdata}, 16'h0000);
      chk("rst_busy", {h1_busy, h0_busy}, 2'b00);
      chk("rst_ovf", ovf_sticky, 2'b00);
      chk("rst_state", arb_state_mon, 2'd0);
      resetb = 1'b1;
      cyc();

      // Simultaneous reads out of reset: host 0 first
      cyc(); drive(0, 1'b1, 8'h01, 8'h00, 1'b0); drive(1, 1'b1, 8'h02, 8'h00, 1'b0);
      cyc(); chk("pair1_busy", {h1_busy, h0_busy}, 2'b11);
             drive(0, 1'b0, 8'h00, 8'h00, 1'b0); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(); chk("pair1_issue0_en", rb_reg_en, 1'b1); chk("pair1_issue0_addr", rb_address, 8'h01);
             chk("pair1_issue0_state", arb_state_mon, 2'd1);
      cyc(); chk("pair1_h0_rvalid", {h1_rvalid, h0_rvalid}, 2'b01); chk("pair1_h0_rdata", h0_rdata, 8'h3C);
             chk("pair1_resp_state", arb_state_mon, 2'd2);
      cyc(); chk("pair1_idle_busy", {h1_busy, h0_busy}, 2'b10); chk("pair1_h0_hold", h0_rdata, 8'h3C);
             chk("pair1_rvalid_drop", h0_rvalid, 1'b0);
      cyc(); chk("pair1_issue1_en", rb_reg_en, 1'b1); chk("pair1_issue1_addr", rb_address, 8'h02);
      cyc(); chk("pair1_h1_rvalid", {h1_rvalid, h0_rvalid}, 2'b10); chk("pair1_h1_rdata", h1_rdata, 8'h3F);
      cyc(); chk("pair1_done_busy", {h1_busy, h0_busy}, 2'b00); chk("pair1_done_state", arb_state_mon, 2'd0);

      // Single read from host 0 (sets last = 0)
      cyc(); drive(0, 1'b1, 8'h01, 8'h00, 1'b0);
      cyc(); chk("rd0_busy", h0_busy, 1'b1); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(); chk("rd0_en", {rb_reg_en, rb_write_en}, 2'b10); chk("rd0_addr", rb_address, 8'h01);
      cyc(); chk("rd0_rvalid", h0_rvalid, 1'b1); chk("rd0_rdata", h0_rdata, 8'h3C);
             chk("rd0_resp_busy", h0_busy, 1'b1);
      cyc(); chk("rd0_rvalid_drop", h0_rvalid, 1'b0); chk("rd0_hold", h0_rdata, 8'h3C);
             chk("rd0_busy_low", h0_busy, 1'b0);

      // Repeated simultaneous pair: host 1 first now
      cyc(); drive(0, 1'b1, 8'h01, 8'h00, 1'b0); drive(1, 1'b1, 8'h02, 8'h00, 1'b0);
      cyc(); drive(0, 1'b0, 8'h00, 8'h00, 1'b0); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(); chk("pair2_first_addr", rb_address, 8'h02);
      cyc(); chk("pair2_first_rvalid", {h1_rvalid, h0_rvalid}, 2'b10);
      cyc();
      cyc(); chk("pair2_second_addr", rb_address, 8'h01); chk("pair2_second_en", rb_reg_en, 1'b1);
      cyc(); chk("pair2_second_rvalid", {h1_rvalid, h0_rvalid}, 2'b01);
      cyc();

      // Single write from host 1
      cyc(); drive(1, 1'b1, 8'h02, 8'h80, 1'b1);
      cyc(); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(); chk("wr1_en", {rb_reg_en, rb_write_en}, 2'b11); chk("wr1_addr", rb_address, 8'h02);
             chk("wr1_wdata", rb_wdata, 8'h80);
      cyc(); chk("wr1_no_rvalid", h1_rvalid, 1'b0); chk("wr1_strobe_off", {rb_reg_en, rb_write_en}, 2'b00);
             chk("wr1_addr_hold", rb_address, 8'h02); chk("wr1_resp_busy", h1_busy, 1'b1);
      cyc(); chk("wr1_busy_low", h1_busy, 1'b0); chk("wr1_h1_rdata_hold", h1_rdata, 8'h3F);

      // Host 1 strobes on consecutive cycles: second dropped
      cyc(); drive(1, 1'b1, 8'h03, 8'h00, 1'b0);
      cyc(); chk("ovf_before", ovf_sticky, 2'b00); drive(1, 1'b1, 8'h04, 8'h00, 1'b0);
      cyc(); drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
             chk("ovf_set", ovf_sticky, 2'b10); chk("ovf_first_addr", rb_address, 8'h03);
      cyc(); chk("ovf_rvalid", h1_rvalid, 1'b1); chk("ovf_rdata", h1_rdata, 8'h3E);
      cyc(); chk("ovf_busy_low", h1_busy, 1'b0);
      cyc(); chk("ovf_no_second", rb_reg_en, 1'b0); chk("ovf_idle", arb_state_mon, 2'd0);

      // Host 0 strobe during its own RESP is captured
      cyc(); drive(0, 1'b1, 8'h01, 8'h00, 1'b0);
      cyc(); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc();
      cyc(); chk("rel_resp_state", arb_state_mon, 2'd2); chk("rel_rvalid", h0_rvalid, 1'b1);
             drive(0, 1'b1, 8'h02, 8'h11, 1'b1);
      cyc(); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
             chk("rel_busy_kept", h0_busy, 1'b1); chk("rel_ovf_clear", ovf_sticky, 2'b10);
      cyc(); chk("rel_second_en", {rb_reg_en, rb_write_en}, 2'b11);
             chk("rel_second_addr", rb_address, 8'h02); chk("rel_second_wdata", rb_wdata, 8'h11);
      cyc(); chk("rel_second_no_rvalid", h0_rvalid, 1'b0);
      cyc(); chk("rel_busy_low", h0_busy, 1'b0);

      // Reset asserted during ISSUE of a read
      cyc(); drive(0, 1'b1, 8'h05, 8'h00, 1'b0);
      cyc(); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
      cyc(); chk("rstmid_issue", arb_state_mon, 2'd1); resetb = 1'b0;
      cyc(); chk("rstmid_state", arb_state_mon, 2'd0); chk("rstmid_busy", {h1_busy, h0_busy}, 2'b00);
             chk("rstmid_rvalid", {h1_rvalid, h0_rvalid}, 2'b00); chk("rstmid_ovf", ovf_sticky, 2'b00);
             chk("rstmid_rdata", h0_rdata, 8'h00);
             resetb = 1'b1;
      cyc(); chk("rstmid_rvalid_after", h0_rvalid, 1'b0); chk("rstmid_state_after", arb_state_mon, 2'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
